// File: rtl/pg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pg_pkg
// Description : Shared widths, latency default and state codes for the
//               pattern-generator divider sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package pg_pkg;

    localparam int c_W_DEFAULT       = 12;
    localparam int c_DIV_LAT_DEFAULT = 1;

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_LOAD  = 3'd1;
    localparam logic [2:0] c_ST_SWEEP = 3'd2;
    localparam logic [2:0] c_ST_DRAIN = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

endpackage
`default_nettype wire

// File: rtl/pg_div_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : pg_div_seq_if
// Description : Control-side and divider-side signals of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface pg_div_seq_if
    import pg_pkg::*;
#(
    parameter int W = c_W_DEFAULT
) ();

    logic         start;
    logic         abort;
    logic [W-1:0] cfg_total;
    logic [W-1:0] cfg_divisor;
    logic         div_reset;
    logic [W-1:0] div_dividend;
    logic [W-1:0] div_divisor;
    logic [W-1:0] div_cnt;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         err_cfg;

    // master: register/control logic plus the divider; slave: the sequencer
    modport master (
        output start, abort, cfg_total, cfg_divisor, div_cnt,
        input  div_reset, div_dividend, div_divisor, busy, done, result, err_cfg
    );

    modport slave (
        input  start, abort, cfg_total, cfg_divisor, div_cnt,
        output div_reset, div_dividend, div_divisor, busy, done, result, err_cfg
    );

endinterface
`default_nettype wire

// File: rtl/pg_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : pg_div_seq
// Description : Sweeps 1..total into ff_divider and reports floor(total/divisor).
// Revision    : 1.0 - initial release
// ============================================================================
module pg_div_seq
    import pg_pkg::*;
#(
    parameter int W       = c_W_DEFAULT,
    parameter int DIV_LAT = c_DIV_LAT_DEFAULT
) (
    input  wire logic    clk,
    input  wire logic    rst_n,
    pg_div_seq_if.slave  bus
);

    localparam int              c_DRW        = (DIV_LAT > 1) ? $clog2(DIV_LAT) : 1;
    localparam logic [c_DRW-1:0] c_DRAIN_LOAD = c_DRW'(DIV_LAT - 1);

    logic [2:0]       r_state;
    logic [W-1:0]     r_total;
    logic [c_DRW-1:0] r_drain;
    logic             r_degen;
    logic             r_div_reset;
    logic [W-1:0]     r_dividend;
    logic [W-1:0]     r_divisor;
    logic             r_busy;
    logic             r_done;
    logic [W-1:0]     r_result;
    logic             r_err_cfg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_IDLE;
            r_total     <= '0;
            r_drain     <= '0;
            r_degen     <= 1'b0;
            r_div_reset <= 1'b0;
            r_dividend  <= '0;
            r_divisor   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= '0;
            r_err_cfg   <= 1'b0;
        end else if (bus.abort && (r_state != c_ST_IDLE)) begin
            r_state     <= c_ST_IDLE;
            r_div_reset <= 1'b0;
            r_dividend  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_div_reset <= 1'b0;
                    r_dividend  <= '0;
                    r_done      <= 1'b0;
                    if (bus.start && !bus.abort) begin
                        r_total   <= bus.cfg_total;
                        r_divisor <= bus.cfg_divisor;
                        r_err_cfg <= 1'b0;
                        r_busy    <= 1'b1;
                        // Degenerate configs spend one DRAIN cycle so done lands after edge 1.
                        if ((bus.cfg_total == '0) || (bus.cfg_divisor == '0)) begin
                            r_state <= c_ST_DRAIN;
                            r_drain <= '0;
                            r_degen <= 1'b1;
                        end else begin
                            r_state     <= c_ST_LOAD;
                            r_div_reset <= 1'b1;
                            r_degen     <= 1'b0;
                        end
                    end
                end

                c_ST_LOAD: begin
                    r_div_reset <= 1'b0;
                    r_dividend  <= W'(1);
                    r_state     <= c_ST_SWEEP;
                end

                c_ST_SWEEP: begin
                    if (r_dividend == r_total) begin
                        r_dividend <= '0;
                        r_drain    <= c_DRAIN_LOAD;
                        r_state    <= c_ST_DRAIN;
                    end else begin
                        r_dividend <= r_dividend + W'(1);
                    end
                end

                c_ST_DRAIN: begin
                    if (r_drain == '0) begin
                        r_state   <= c_ST_DONE;
                        r_done    <= 1'b1;
                        r_result  <= r_degen ? '0 : bus.div_cnt;
                        r_err_cfg <= (r_divisor == '0);
                    end else begin
                        r_drain <= r_drain - c_DRW'(1);
                    end
                end

                c_ST_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= c_ST_IDLE;
                end

                default: begin
                    r_state     <= c_ST_IDLE;
                    r_div_reset <= 1'b0;
                    r_dividend  <= '0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                end
            endcase
        end
    end

    assign bus.div_reset    = r_div_reset;
    assign bus.div_dividend = r_dividend;
    assign bus.div_divisor  = r_divisor;
    assign bus.busy         = r_busy;
    assign bus.done         = r_done;
    assign bus.result       = r_result;
    assign bus.err_cfg      = r_err_cfg;

endmodule
`default_nettype wire

// File: tb/tb_pg_div_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_pg_div_seq
// Description : Self-checking bench for pg_div_seq with a behavioural divider.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pg_div_seq;

    localparam int W       = 12;
    localparam int DIV_LAT = 1;

    logic clk;
    logic rst_n;
    int   n_total;
    int   n_bad;

    pg_div_seq_if #(.W(W)) bus ();

    pg_div_seq #(.W(W), .DIV_LAT(DIV_LAT)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Divider stand-in: counts dividends that are multiples of the divisor, one cycle late.
    logic [W-1:0] r_tb_cnt;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_tb_cnt <= '0;
        else if (bus.div_reset)
            r_tb_cnt <= '0;
        else if (bus.div_dividend != '0 && bus.div_divisor != '0 &&
                 (bus.div_dividend % bus.div_divisor) == '0)
            r_tb_cnt <= r_tb_cnt + W'(1);
    end
    assign bus.div_cnt = r_tb_cnt;

    typedef struct {
        int total;
        int divisor;
        int exp_res;
        bit exp_err;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic wait_dividend(input int v);
        int n;
        n = 0;
        while (bus.div_dividend != W'(v) && n < 5000) begin
            @(posedge clk); #1;
            n++;
        end
        check("wait_dividend_timeout", (n < 5000) ? 1 : 0, 1);
    endtask

    // Runs one start..done transaction; poke>0 re-pulses start with other cfg mid-run.
    task automatic run_op(input int tot, input int dv, input int poke,
                          input int exp_res, input bit exp_err);
        int n, seq_bad, rst_cnt, exp_div;
        bit normal, got_done;
        normal = (tot != 0) && (dv != 0);
        bus.cfg_total   = W'(tot);
        bus.cfg_divisor = W'(dv);
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("busy_after_start", bus.busy, 1);
        rst_cnt  = bus.div_reset ? 1 : 0;
        seq_bad  = 0;
        got_done = 1'b0;
        n        = 0;
        while (!got_done && n < tot + DIV_LAT + 20) begin
            @(posedge clk); #1;
            n++;
            if (bus.div_reset) rst_cnt++;
            exp_div = (normal && n <= tot) ? n : 0;
            if (int'(bus.div_dividend) != exp_div) seq_bad++;
            if (bus.done) got_done = 1'b1;
            if (poke != 0 && n == poke) begin
                bus.start       = 1'b1;
                bus.cfg_total   = W'(30);
                bus.cfg_divisor = W'(2);
            end else begin
                bus.start = 1'b0;
            end
        end
        bus.start = 1'b0;
        check("done_seen", got_done, 1);
        check("done_latency", n, normal ? tot + DIV_LAT + 1 : 1);
        check("result", bus.result, exp_res);
        check("err_cfg", bus.err_cfg, exp_err);
        check("div_reset_pulses", rst_cnt, normal ? 1 : 0);
        check("dividend_seq_errors", seq_bad, 0);
        check("div_divisor_held", bus.div_divisor, dv);
        @(posedge clk); #1;
        check("idle_after_done", {bus.busy, bus.done}, 0);
    endtask

    initial begin
        int tot, dv;
        n_total = 0;
        n_bad   = 0;
        rst_n           = 1'b0;
        bus.start       = 1'b0;
        bus.abort       = 1'b0;
        bus.cfg_total   = '0;
        bus.cfg_divisor = '0;

        vecs[0] = '{100,  7,    14,   1'b0};
        vecs[1] = '{4095, 4095, 1,    1'b0};
        vecs[2] = '{4095, 1,    4095, 1'b0};
        vecs[3] = '{50,   0,    0,    1'b1};
        vecs[4] = '{50,   5,    10,   1'b0};
        vecs[5] = '{0,    5,    0,    1'b0};
        vecs[6] = '{1,    1,    1,    1'b0};
        vecs[7] = '{3,    5,    0,    1'b0};

        #3;
        check("reset_outputs",
              {bus.div_reset, bus.div_dividend, bus.div_divisor, bus.busy,
               bus.done, bus.result, bus.err_cfg}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++)
            run_op(vecs[i].total, vecs[i].divisor, 0, vecs[i].exp_res, vecs[i].exp_err);

        // Abort mid-sweep: no done, result keeps the last completed value.
        bus.cfg_total   = W'(200);
        bus.cfg_divisor = W'(9);
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_dividend(60);
        bus.abort = 1'b1;
        @(posedge clk); #1;
        bus.abort = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_outputs", {bus.div_reset, bus.div_dividend, bus.done}, 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("abort_no_done", bus.done, 0);
        end
        check("abort_result_kept", bus.result, vecs[7].exp_res);

        run_op(200, 9, 0, 22, 1'b0);
        run_op(100, 7, 40, 14, 1'b0);

        // start together with abort in IDLE is dropped
        bus.cfg_total   = W'(20);
        bus.cfg_divisor = W'(3);
        bus.start       = 1'b1;
        bus.abort       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_busy", {bus.busy, bus.div_reset}, 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("start_abort_no_done", {bus.busy, bus.done}, 0);
        end
        check("start_abort_result", bus.result, 14);

        for (int i = 0; i < 12; i++) begin
            tot = int'($urandom_range(0, 300));
            dv  = int'($urandom_range(0, 40));
            run_op(tot, dv, 0, (dv == 0) ? 0 : tot / dv, dv == 0);
        end

        // Asynchronous reset mid-sweep
        bus.cfg_total   = W'(100);
        bus.cfg_divisor = W'(7);
        bus.start       = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        wait_dividend(30);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_outputs",
              {bus.div_reset, bus.div_dividend, bus.div_divisor, bus.busy,
               bus.done, bus.result, bus.err_cfg}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        run_op(10, 3, 0, 3, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pg_div_seq.md
Name: pg_div_seq

Overview:
Sequencer for the pattern-generator frame/count divider (ff_divider). On a start request it latches a configuration, issues the divider's synchronous reset with the latched divisor, and sweeps a position counter 1..total into the divider's dividend. It then waits out the divider latency, captures the divider's count (floor(total/divisor)) and reports it with a one-cycle done pulse. It sits between the PG register/control logic and one ff_divider instance.

Parameters:
W, 12, datapath width of total, divisor, dividend and count (matches divider)
DIV_LAT, 1, cycles from last dividend presented to divider count stable (drain cycles, >=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle request; sampled only in IDLE
abort  input  1  cancel current operation; highest priority after rst_n
cfg_total  input  W  sweep end value; latched on accepted start
cfg_divisor  input  W  divisor; latched on accepted start
div_reset  output  1  to divider reset; one-cycle pulse in LOAD
div_dividend  output  W  to divider dividend; sweep position
div_divisor  output  W  to divider divisor; latched divisor
div_cnt  input  W  from divider ff_cnt
busy  output  1  high in any state except IDLE
done  output  1  one-cycle pulse on completion
result  output  W  captured count; holds until next completion
err_cfg  output  1  set with done when latched divisor==0; cleared on next accepted start

Behaviour:
- Clock clk, reset rst_n asynchronous active-low. Reset: state IDLE; div_reset, div_dividend, div_divisor, busy, done, result, err_cfg all 0; drain counter 0.
- All outputs registered.
- States: IDLE, LOAD, SWEEP, DRAIN, DONE.
- IDLE: start=1 -> latch cfg_total/cfg_divisor, clear err_cfg. If total==0 or divisor==0 -> DONE (err_cfg=1 iff divisor==0, result captured as 0, divider not touched). Else -> LOAD.
- LOAD (1 cycle): div_reset=1, div_divisor=latched divisor, div_dividend=0 -> SWEEP with div_dividend=1.
- SWEEP: div_dividend increments by 1 per cycle; when div_dividend==total -> DRAIN and div_dividend returns to 0. Dividend never exceeds total; no wrap possible since total<=2^W-1.
- DRAIN: DIV_LAT cycles, div_dividend=0 -> DONE, capturing result<=div_cnt on the transition edge.
- DONE (1 cycle): done=1 -> IDLE. busy drops the edge DONE is left.
- Timing (DIV_LAT=1, normal case): start sampled at edge 0; div_reset high after edge 0; dividend=k after edge k (k=1..total); done high after edge total+DIV_LAT+1.
- Degenerate case: done high after edge 1.
- start while busy: ignored, no queuing. cfg_* changes while busy: no effect.
- abort=1 in any non-IDLE state -> IDLE next edge; div_reset and div_dividend 0, no done, result and err_cfg unchanged. abort and start in the same IDLE cycle: abort wins, start dropped.
- rst_n asserted mid-operation: immediate return to reset values.
- div_divisor holds its latched value after completion until next accepted start.

Decomposition:
- Shared package pg_pkg: W default, state encoding (IDLE/LOAD/SWEEP/DRAIN/DONE as 3-bit constants), DIV_LAT default.
- No sub-module required. Optional wrapper pg_div_unit instantiates pg_div_seq plus ff_divider for verification.

Test Plan:
- total=100, divisor=7, start -> one div_reset pulse, dividend 1..100 on consecutive cycles, done after edge 102, result=14, err_cfg=0.
- total=4095, divisor=4095 -> result=1. Then total=4095, divisor=1 -> result=4095. No false matches from divider cmp wrap.
- total=50, divisor=0 -> done after edge 1, result=0, err_cfg=1, div_reset never asserted. Next start with divisor=5, total=50 -> err_cfg=0, result=10.
- total=200, divisor=9; abort at dividend=60 -> IDLE next edge, busy=0, no done, result keeps previous value. Immediate restart (same cfg) -> result=22.
- start pulsed again during SWEEP with different cfg -> ignored; result reflects original cfg. Simultaneous start+abort in IDLE -> stays IDLE.
- rst_n low at dividend=30 of total=100 -> all outputs 0 asynchronously. After release, start total=10, divisor=3 -> result=3.
